// File: rtl/bus_arbiter.sv
// Bus arbiter between a CPU and a DMA engine sharing one memory port.
// The DMA engine gets the bus after the CPU has been halted for HALT_DELAY
// cycles, keeps it for at most BURST accesses, and then the CPU is
// guaranteed CPU_SLOTS cycles of ownership before the next DMA grant.
module bus_arbiter #(
    parameter int HALT_DELAY = 2,
    parameter int BURST      = 4,
    parameter int CPU_SLOTS  = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cpu_write_in,
    input  logic [15:0] cpu_addr_in,
    input  logic [7:0]  cpu_wdata_in,
    output logic        cpu_halt_out,
    input  logic        dma_req_in,
    input  logic        dma_write_in,
    input  logic [15:0] dma_addr_in,
    input  logic [7:0]  dma_wdata_in,
    output logic        dma_ack_out,
    output logic [7:0]  dma_rdata_out,
    output logic        mem_write_out,
    output logic [15:0] mem_addr_out,
    output logic [7:0]  mem_wdata_out,
    input  logic [7:0]  mem_rdata_in,
    output logic        owner_out
);

    typedef enum logic [1:0] {
        ST_CPU     = 2'd0,
        ST_HALTING = 2'd1,
        ST_DMA     = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    // Terminal counts for the timed states; counters run 0..LAST inclusive.
    localparam logic [3:0] HALT_LAST = 4'(HALT_DELAY - 1);
    localparam logic [3:0] SLOT_LAST = 4'(CPU_SLOTS - 1);
    localparam logic [7:0] BURST_MAX = 8'(BURST);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [7:0]  beat_q;
    logic [7:0]  beat_d;
    logic        halt_q;
    logic        ack_q;
    logic [7:0]  rdata_q;

    // Beat count after the access completing at the coming edge.
    always_comb begin
        beat_d = beat_q + 8'd1;
    end

    // Arbitration FSM with registered halt, ack and read-data outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_CPU;
            cnt_q   <= 4'd0;
            beat_q  <= 8'd0;
            halt_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            // Ack is a single-cycle pulse; only a DMA access re-asserts it.
            ack_q <= 1'b0;
            case (state_q)
                ST_CPU: begin
                    if (dma_req_in) begin
                        state_q <= ST_HALTING;
                        cnt_q   <= 4'd0;
                        halt_q  <= 1'b1;
                    end
                end
                ST_HALTING: begin
                    // A request dropped here is not aborted; DMA exits on its first edge.
                    if (cnt_q == HALT_LAST) begin
                        state_q <= ST_DMA;
                        cnt_q   <= 4'd0;
                        beat_q  <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_DMA: begin
                    if (dma_req_in) begin
                        ack_q   <= 1'b1;
                        rdata_q <= mem_rdata_in;
                        beat_q  <= beat_d;
                        if (beat_d == BURST_MAX) begin
                            state_q <= ST_RECOVER;
                            cnt_q   <= 4'd0;
                            halt_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= ST_RECOVER;
                        cnt_q   <= 4'd0;
                        halt_q  <= 1'b0;
                    end
                end
                ST_RECOVER: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_q <= ST_CPU;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= ST_CPU;
                    cnt_q   <= 4'd0;
                    halt_q  <= 1'b0;
                end
            endcase
        end
    end

    // Memory port mux: CPU passes through except while halting (writes
    // blocked) and during DMA ownership.
    always_comb begin
        mem_addr_out  = cpu_addr_in;
        mem_wdata_out = cpu_wdata_in;
        mem_write_out = cpu_write_in;
        owner_out     = 1'b0;
        case (state_q)
            ST_HALTING: begin
                mem_write_out = 1'b0;
            end
            ST_DMA: begin
                mem_addr_out  = dma_addr_in;
                mem_wdata_out = dma_wdata_in;
                mem_write_out = dma_write_in & dma_req_in;
                owner_out     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign cpu_halt_out  = halt_q;
    assign dma_ack_out   = ack_q;
    assign dma_rdata_out = rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter at default parameters
// (HALT_DELAY=2, BURST=4, CPU_SLOTS=2).
module tb_bus_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        cpu_write_in;
    logic [15:0] cpu_addr_in;
    logic [7:0]  cpu_wdata_in;
    logic        cpu_halt_out;
    logic        dma_req_in;
    logic        dma_write_in;
    logic [15:0] dma_addr_in;
    logic [7:0]  dma_wdata_in;
    logic        dma_ack_out;
    logic [7:0]  dma_rdata_out;
    logic        mem_write_out;
    logic [15:0] mem_addr_out;
    logic [7:0]  mem_wdata_out;
    logic [7:0]  mem_rdata_in;
    logic        owner_out;

    int n_checks = 0;
    int n_fail   = 0;

    bus_arbiter dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .cpu_write_in  (cpu_write_in),
        .cpu_addr_in   (cpu_addr_in),
        .cpu_wdata_in  (cpu_wdata_in),
        .cpu_halt_out  (cpu_halt_out),
        .dma_req_in    (dma_req_in),
        .dma_write_in  (dma_write_in),
        .dma_addr_in   (dma_addr_in),
        .dma_wdata_in  (dma_wdata_in),
        .dma_ack_out   (dma_ack_out),
        .dma_rdata_out (dma_rdata_out),
        .mem_write_out (mem_write_out),
        .mem_addr_out  (mem_addr_out),
        .mem_wdata_out (mem_wdata_out),
        .mem_rdata_in  (mem_rdata_in),
        .owner_out     (owner_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        exp_wr;
        logic [15:0] exp_addr;
        logic [7:0]  exp_wdata;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        dma_req_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int acks;
        int wr_pulses;
        logic exp_halt [1:10];
        logic exp_ack  [1:10];
        logic exp_own  [1:10];

        vecs[0] = '{1'b1, 16'h0100, 8'h5A, 1'b1, 16'h0100, 8'h5A};
        vecs[1] = '{1'b0, 16'hFFFF, 8'h00, 1'b0, 16'hFFFF, 8'h00};
        vecs[2] = '{1'b1, 16'h0000, 8'hFF, 1'b1, 16'h0000, 8'hFF};
        vecs[3] = '{1'b0, 16'h8001, 8'h81, 1'b0, 16'h8001, 8'h81};

        rst_in       = 1'b1;
        cpu_write_in = 1'b0;
        cpu_addr_in  = 16'h0000;
        cpu_wdata_in = 8'h00;
        dma_req_in   = 1'b0;
        dma_write_in = 1'b0;
        dma_addr_in  = 16'h0000;
        dma_wdata_in = 8'h00;
        mem_rdata_in = 8'h00;

        // Reset state, with a DMA request present that must be ignored.
        dma_req_in = 1'b1;
        tick();
        tick();
        check("reset halt", cpu_halt_out, 0);
        check("reset ack", dma_ack_out, 0);
        check("reset rdata", dma_rdata_out, 8'h00);
        check("reset owner", owner_out, 0);
        dma_req_in = 1'b0;
        rst_in = 1'b0;

        // Idle CPU pass-through vectors.
        for (int i = 0; i < 4; i++) begin
            cpu_write_in = vecs[i].wr;
            cpu_addr_in  = vecs[i].addr;
            cpu_wdata_in = vecs[i].wdata;
            #1;
            check($sformatf("idle%0d write", i), mem_write_out, vecs[i].exp_wr);
            check($sformatf("idle%0d addr", i), mem_addr_out, vecs[i].exp_addr);
            check($sformatf("idle%0d wdata", i), mem_wdata_out, vecs[i].exp_wdata);
            check($sformatf("idle%0d owner", i), owner_out, 0);
            tick();
            check($sformatf("idle%0d halt", i), cpu_halt_out, 0);
        end
        cpu_write_in = 1'b0;

        // Single DMA read of 16'hF000.
        do_reset();
        cpu_addr_in  = 16'h1234;
        cpu_write_in = 1'b1;
        dma_req_in   = 1'b1;
        dma_write_in = 1'b0;
        dma_addr_in  = 16'hF000;
        mem_rdata_in = 8'h3C;
        tick(); // edge 1
        check("rd e1 halt", cpu_halt_out, 1);
        check("rd e1 owner", owner_out, 0);
        check("rd e1 halting write blocked", mem_write_out, 0);
        check("rd e1 halting addr", mem_addr_out, 16'h1234);
        tick(); // edge 2
        check("rd e2 owner", owner_out, 0);
        tick(); // edge 3
        check("rd e3 owner", owner_out, 1);
        check("rd e3 addr", mem_addr_out, 16'hF000);
        check("rd e3 ack", dma_ack_out, 0);
        tick(); // edge 4: access completes
        check("rd e4 ack", dma_ack_out, 1);
        check("rd e4 rdata", dma_rdata_out, 8'h3C);
        dma_req_in   = 1'b0;
        cpu_write_in = 1'b0;
        tick(); // edge 5: request gone, exit
        check("rd e5 ack", dma_ack_out, 0);
        check("rd e5 halt", cpu_halt_out, 0);
        check("rd e5 owner", owner_out, 0);
        tick();
        tick();
        check("rd e7 halt", cpu_halt_out, 0);

        // Burst limit with request held high.
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            exp_halt[e] = (e <= 6) || (e == 10);
            exp_ack[e]  = (e >= 4) && (e <= 7);
            exp_own[e]  = (e >= 3) && (e <= 6);
        end
        acks = 0;
        dma_req_in = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            mem_rdata_in = 8'(8'h10 + e);
            tick();
            if (dma_ack_out) acks++;
            check($sformatf("burst e%0d halt", e), cpu_halt_out, exp_halt[e]);
            check($sformatf("burst e%0d ack", e), dma_ack_out, exp_ack[e]);
            check($sformatf("burst e%0d owner", e), owner_out, exp_own[e]);
            if (exp_ack[e])
                check($sformatf("burst e%0d rdata", e), dma_rdata_out, 8'h10 + e);
        end
        check("burst ack count", acks, 4);

        // DMA write of 8'hA5 to 16'h3FFF.
        do_reset();
        dma_req_in   = 1'b1;
        dma_write_in = 1'b1;
        dma_addr_in  = 16'h3FFF;
        dma_wdata_in = 8'hA5;
        tick();
        tick();
        tick(); // edge 3: DMA
        check("wr owner", owner_out, 1);
        check("wr mem_write", mem_write_out, 1);
        check("wr addr", mem_addr_out, 16'h3FFF);
        check("wr wdata", mem_wdata_out, 8'hA5);
        tick(); // edge 4: ack
        check("wr ack", dma_ack_out, 1);
        dma_req_in = 1'b0;
        #1;
        check("wr no strobe without req", mem_write_out, 0);
        tick();
        check("wr exit halt", cpu_halt_out, 0);
        dma_write_in = 1'b0;

        // Request dropped during HALTING.
        do_reset();
        acks = 0;
        wr_pulses = 0;
        dma_req_in   = 1'b1;
        dma_write_in = 1'b1;
        tick(); // edge 1: HALTING
        check("drop e1 halt", cpu_halt_out, 1);
        dma_req_in = 1'b0;
        for (int e = 2; e <= 7; e++) begin
            tick();
            if (dma_ack_out) acks++;
            if (mem_write_out) wr_pulses++;
            if (e == 3) check("drop e3 owner", owner_out, 1);
            if (e == 4) check("drop e4 halt", cpu_halt_out, 0);
            if (e == 5) check("drop e5 owner", owner_out, 0);
        end
        check("drop ack count", acks, 0);
        check("drop write pulses", wr_pulses, 0);
        dma_write_in = 1'b0;

        // Reset in the middle of a burst, after two acks.
        do_reset();
        dma_req_in   = 1'b1;
        mem_rdata_in = 8'h77;
        for (int e = 1; e <= 5; e++) tick();
        check("midrst pre ack", dma_ack_out, 1);
        check("midrst pre beat data", dma_rdata_out, 8'h77);
        rst_in = 1'b1;
        tick();
        check("midrst halt", cpu_halt_out, 0);
        check("midrst ack", dma_ack_out, 0);
        check("midrst rdata", dma_rdata_out, 8'h00);
        check("midrst owner", owner_out, 0);
        rst_in = 1'b0;
        dma_req_in = 1'b0;
        tick();
        check("midrst after halt", cpu_halt_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
